// File: rtl/smc_regctl_pkg.sv
// Shared command codes and FSM encoding for the SMC register controller.
package smc_regctl_pkg;
  localparam logic [7:0] CMD_POWER   = 8'h01;
  localparam logic [7:0] CMD_RESET   = 8'h02;
  localparam logic [7:0] CMD_LED     = 8'h05;
  localparam logic [7:0] CMD_KBD     = 8'h07;
  localparam logic [7:0] CMD_VERSION = 8'h30;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RDATA = 2'd3;
endpackage

// File: rtl/smc_regctl_if.sv
// Byte-level I2C slave side bus between the bit engine (master) and the register controller (slave).
interface smc_regctl_if;
  logic       devsel_i;
  logic       rw_bit_i;
  logic [7:0] rxbyte_i;
  logic       rxbyte_v_i;
  logic [7:0] txbyte_o;
  logic       txbyte_deq_i;

  modport master (output devsel_i, rw_bit_i, rxbyte_i, rxbyte_v_i, txbyte_deq_i, input txbyte_o);
  modport slave  (input devsel_i, rw_bit_i, rxbyte_i, rxbyte_v_i, txbyte_deq_i, output txbyte_o);
endinterface

// File: rtl/smc_fifo.sv
// Keyboard scancode FIFO with extra-MSB pointers; exposes the post-update head so reads can be registered.
module smc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk6x,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic [W-1:0] head_nxt,
  output logic         empty_nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic         empty, push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push && (!full || pop_ok);
  assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);
  assign rd_nxt  = rd_ptr + (AW+1)'(pop_ok);

  assign empty_nxt = (rd_nxt == wr_nxt);
  // If the read pointer catches the write pointer this cycle, the new head is the byte being pushed.
  assign head_nxt  = (push_ok && rd_nxt == wr_ptr) ? wdata : mem[rd_nxt[AW-1:0]];

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  always_ff @(posedge clk6x)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/smc_regctl.sv
// SMC register controller: decodes I2C command/data bytes, drives LED/power requests, serves keyboard FIFO reads.
module smc_regctl
  import smc_regctl_pkg::*;
#(
  parameter int         KBD_DEPTH  = 8,
  parameter logic [7:0] FW_VERSION = 8'h01
) (
  input  logic             clk6x,
  input  logic             resetn,
  smc_regctl_if.slave      bus,
  input  logic [7:0]       kbd_data_i,
  input  logic             kbd_wr_i,
  output logic             kbd_full_o,
  output logic [7:0]       led_o,
  output logic             pwroff_req_o,
  output logic             reset_req_o
);
  logic [1:0] state, state_nxt;
  logic [7:0] cmd, cmd_nxt, led_nxt, tx_nxt, head_nxt;
  logic       wr_act, cmd_lat, kbd_pop, empty_nxt;

  always_comb begin
    state_nxt = state;
    if (!bus.devsel_i) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  state_nxt = bus.rw_bit_i ? ST_RDATA : ST_CMD;
        ST_CMD:   if (bus.rw_bit_i) state_nxt = ST_RDATA;
                  else if (bus.rxbyte_v_i) state_nxt = ST_WDATA;
        ST_WDATA: if (bus.rw_bit_i) state_nxt = ST_RDATA;
        default:  if (!bus.rw_bit_i) state_nxt = ST_CMD;
      endcase
    end
  end

  assign cmd_lat = (state == ST_CMD)   && bus.devsel_i && !bus.rw_bit_i && bus.rxbyte_v_i;
  assign wr_act  = (state == ST_WDATA) && bus.devsel_i && !bus.rw_bit_i && bus.rxbyte_v_i;
  assign kbd_pop = (state == ST_RDATA) && bus.devsel_i && bus.rw_bit_i && bus.txbyte_deq_i
                   && (cmd == CMD_KBD);

  assign cmd_nxt = cmd_lat ? bus.rxbyte_i : cmd;
  assign led_nxt = (wr_act && cmd == CMD_LED) ? bus.rxbyte_i : led_o;

  // Read data is built from next-cycle state so it tracks a pop or LED write with one cycle of latency.
  always_comb begin
    case (cmd_nxt)
      CMD_LED:     tx_nxt = led_nxt;
      CMD_KBD:     tx_nxt = empty_nxt ? 8'h00 : head_nxt;
      CMD_VERSION: tx_nxt = FW_VERSION;
      default:     tx_nxt = 8'hFF;
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      cmd          <= 8'h00;
      led_o        <= 8'h00;
      bus.txbyte_o <= 8'hFF;
      pwroff_req_o <= 1'b0;
      reset_req_o  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cmd          <= cmd_nxt;
      led_o        <= led_nxt;
      bus.txbyte_o <= tx_nxt;
      pwroff_req_o <= wr_act && (cmd == CMD_POWER) && (bus.rxbyte_i == 8'h00);
      reset_req_o  <= wr_act && (((cmd == CMD_POWER) && (bus.rxbyte_i == 8'h01))
                                 || (cmd == CMD_RESET));
    end
  end

  smc_fifo #(.W(8), .DEPTH(KBD_DEPTH)) u_fifo (
    .clk6x     (clk6x),
    .resetn    (resetn),
    .push      (kbd_wr_i),
    .wdata     (kbd_data_i),
    .pop       (kbd_pop),
    .full      (kbd_full_o),
    .head_nxt  (head_nxt),
    .empty_nxt (empty_nxt)
  );
endmodule

// File: tb/tb_smc_regctl.sv
// Directed bench for smc_regctl: writes, pulses, keyboard FIFO reads, overflow and mid-transfer reset.
module tb_smc_regctl;
  import smc_regctl_pkg::*;

  logic       clk6x = 1'b0;
  logic       resetn;
  logic [7:0] kbd_data;
  logic       kbd_wr;
  logic       kbd_full;
  logic [7:0] led;
  logic       pwroff_req, reset_req;
  int         n_chk = 0;
  int         n_fail = 0;

  smc_regctl_if bus ();

  smc_regctl #(.KBD_DEPTH(8), .FW_VERSION(8'h01)) dut (
    .clk6x        (clk6x),
    .resetn       (resetn),
    .bus          (bus),
    .kbd_data_i   (kbd_data),
    .kbd_wr_i     (kbd_wr),
    .kbd_full_o   (kbd_full),
    .led_o        (led),
    .pwroff_req_o (pwroff_req),
    .reset_req_o  (reset_req)
  );

  always #10 clk6x = ~clk6x;

  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic start_write();
    bus.devsel_i = 1'b1;
    bus.rw_bit_i = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rxbyte_i   = b;
    bus.rxbyte_v_i = 1'b1;
    tick();
    bus.rxbyte_v_i = 1'b0;
  endtask

  task automatic rep_start_read();
    bus.rw_bit_i = 1'b1;
    tick();
  endtask

  task automatic start_read();
    bus.devsel_i = 1'b1;
    bus.rw_bit_i = 1'b1;
    tick();
  endtask

  task automatic stop();
    bus.devsel_i = 1'b0;
    bus.rw_bit_i = 1'b0;
    tick();
  endtask

  task automatic read_byte(output logic [7:0] v);
    v = bus.txbyte_o;
    bus.txbyte_deq_i = 1'b1;
    tick();
    bus.txbyte_deq_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    kbd_data = d;
    kbd_wr   = 1'b1;
    tick();
    kbd_wr   = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_chk += 6;
    if (led !== 8'h00)          begin n_fail++; $display("FAIL reset_led got %h want 00", led); end
    if (bus.txbyte_o !== 8'hFF) begin n_fail++; $display("FAIL reset_tx got %h want FF", bus.txbyte_o); end
    if (pwroff_req !== 1'b0)    begin n_fail++; $display("FAIL reset_pwroff got %b want 0", pwroff_req); end
    if (reset_req !== 1'b0)     begin n_fail++; $display("FAIL reset_rstreq got %b want 0", reset_req); end
    if (kbd_full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %b want 0", kbd_full); end
    if (dut.state !== ST_IDLE)  begin n_fail++; $display("FAIL reset_state got %0d want %0d", dut.state, ST_IDLE); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_led();
    logic [7:0] v;
    start_write();
    send_byte(8'h05);
    send_byte(8'hA5);
    n_chk += 3;
    if (led !== 8'hA5)       begin n_fail++; $display("FAIL led_write got %h want A5", led); end
    if (pwroff_req !== 1'b0) begin n_fail++; $display("FAIL led_no_pwroff got %b want 0", pwroff_req); end
    if (reset_req !== 1'b0)  begin n_fail++; $display("FAIL led_no_rstreq got %b want 0", reset_req); end
    send_byte(8'h5A);
    rep_start_read();
    read_byte(v);
    n_chk++;
    if (v !== 8'h5A) begin n_fail++; $display("FAIL led_readback got %h want 5A", v); end
    stop();
  endtask

  task automatic test_pulses();
    start_write();
    send_byte(CMD_POWER);
    send_byte(8'h00);
    n_chk += 2;
    if (pwroff_req !== 1'b1) begin n_fail++; $display("FAIL pwroff_pulse got %b want 1", pwroff_req); end
    if (reset_req !== 1'b0)  begin n_fail++; $display("FAIL pwroff_norst got %b want 0", reset_req); end
    tick();
    n_chk++;
    if (pwroff_req !== 1'b0) begin n_fail++; $display("FAIL pwroff_width got %b want 0", pwroff_req); end
    send_byte(8'h01);
    n_chk += 2;
    if (reset_req !== 1'b1)  begin n_fail++; $display("FAIL rstreq_pulse got %b want 1", reset_req); end
    if (pwroff_req !== 1'b0) begin n_fail++; $display("FAIL rstreq_nopwr got %b want 0", pwroff_req); end
    tick();
    n_chk++;
    if (reset_req !== 1'b0)  begin n_fail++; $display("FAIL rstreq_width got %b want 0", reset_req); end
    send_byte(8'h02);
    n_chk += 2;
    if (reset_req !== 1'b0)  begin n_fail++; $display("FAIL power_other_rst got %b want 0", reset_req); end
    if (pwroff_req !== 1'b0) begin n_fail++; $display("FAIL power_other_pwr got %b want 0", pwroff_req); end
    stop();
    start_write();
    send_byte(CMD_RESET);
    send_byte(8'h77);
    n_chk++;
    if (reset_req !== 1'b1) begin n_fail++; $display("FAIL cmd_reset_pulse got %b want 1", reset_req); end
    stop();
    n_chk++;
    if (reset_req !== 1'b0) begin n_fail++; $display("FAIL cmd_reset_width got %b want 0", reset_req); end
  endtask

  task automatic test_kbd();
    logic [7:0] v;
    logic [7:0] exp [3] = '{8'h1C, 8'h32, 8'h00};
    push(8'h1C);
    push(8'h32);
    start_write();
    send_byte(CMD_KBD);
    rep_start_read();
    for (int i = 0; i < 3; i++) begin
      read_byte(v);
      n_chk++;
      if (v !== exp[i]) begin n_fail++; $display("FAIL kbd_read%0d got %h want %h", i, v, exp[i]); end
    end
    stop();
    push(8'hAB);
    start_read();
    read_byte(v);
    n_chk++;
    if (v !== 8'hAB) begin n_fail++; $display("FAIL kbd_after_empty got %h want AB", v); end
    read_byte(v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL kbd_empty_again got %h want 00", v); end
    stop();
  endtask

  task automatic test_full();
    logic [7:0] v;
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      n_chk++;
      if (kbd_full !== (i == 8)) begin n_fail++; $display("FAIL full_after_push%0d got %b want %b", i, kbd_full, i == 8); end
    end
    push(8'h09);
    n_chk++;
    if (kbd_full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop got %b want 1", kbd_full); end
    start_read();
    // Pop and push together while full: both must take effect.
    v = bus.txbyte_o;
    bus.txbyte_deq_i = 1'b1;
    kbd_data = 8'h0A;
    kbd_wr   = 1'b1;
    tick();
    bus.txbyte_deq_i = 1'b0;
    kbd_wr   = 1'b0;
    n_chk += 2;
    if (v !== 8'h01)       begin n_fail++; $display("FAIL full_first_read got %h want 01", v); end
    if (kbd_full !== 1'b1) begin n_fail++; $display("FAIL full_simul got %b want 1", kbd_full); end
    for (int i = 2; i <= 10; i++) begin
      read_byte(v);
      n_chk++;
      if (v !== ((i <= 8) ? 8'(i) : 8'h0A - 8'(i == 10) * 8'h0A))
        begin n_fail++; $display("FAIL full_read%0d got %h", i, v); end
    end
    n_chk++;
    if (kbd_full !== 1'b0) begin n_fail++; $display("FAIL full_drained got %b want 0", kbd_full); end
    stop();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    start_write();
    send_byte(CMD_LED);
    send_byte(8'h3C);
    n_chk++;
    if (led !== 8'h3C) begin n_fail++; $display("FAIL mid_led_pre got %h want 3C", led); end
    #3 resetn = 1'b0;
    #1;
    n_chk += 3;
    if (led !== 8'h00)          begin n_fail++; $display("FAIL mid_led got %h want 00", led); end
    if (dut.state !== ST_IDLE)  begin n_fail++; $display("FAIL mid_state got %0d want %0d", dut.state, ST_IDLE); end
    if (bus.txbyte_o !== 8'hFF) begin n_fail++; $display("FAIL mid_tx got %h want FF", bus.txbyte_o); end
    bus.devsel_i = 1'b0;
    tick();
    resetn = 1'b1;
    tick(); tick();
    n_chk++;
    if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL mid_wait_idle got %0d want %0d", dut.state, ST_IDLE); end
    start_write();
    send_byte(CMD_VERSION);
    rep_start_read();
    read_byte(v);
    n_chk++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL mid_version got %h want 01", v); end
    stop();
  endtask

  initial begin
    bus.devsel_i     = 1'b0;
    bus.rw_bit_i     = 1'b0;
    bus.rxbyte_i     = 8'h00;
    bus.rxbyte_v_i   = 1'b0;
    bus.txbyte_deq_i = 1'b0;
    kbd_data         = 8'h00;
    kbd_wr           = 1'b0;
    resetn           = 1'b0;
    test_reset();
    test_led();
    test_pulses();
    test_kbd();
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/smc_regctl.md
SMC_REGCTL -- requirements
Module: smc_regctl

Interface
REQ-001 Parameters:
- KBD_DEPTH, default 8, keyboard FIFO depth (power of 2, ≥2).
- FW_VERSION, default 8'h01, value returned by command 0x30.

REQ-002 Ports (name, direction, width, meaning):
- clk6x, in, 1, 48 MHz system clock (the only clock).
- resetn, in, 1, reset; asynchronous, active-low.
- devsel_i, in, 1, I2C slave addressed, transfer ongoing.
- rw_bit_i, in, 1, 1 = master read; valid while devsel_i=1.
- rxbyte_i, in, 8, byte received from master.
- rxbyte_v_i, in, 1, rxbyte_i valid (1 cycle).
- txbyte_o, out, 8, next byte to master; valid whenever devsel_i=1 and rw_bit_i=1.
- txbyte_deq_i, in, 1, txbyte_o consumed (1 cycle).
- kbd_data_i, in, 8, keyboard scancode.
- kbd_wr_i, in, 1, push kbd_data_i (1 cycle).
- kbd_full_o, out, 1, keyboard FIFO full.
- led_o, out, 8, activity LED register.
- pwroff_req_o, out, 1, power-off request pulse (1 cycle).
- reset_req_o, out, 1, system reset request pulse (1 cycle).

Function
REQ-003 FSM states: IDLE, CMD, WDATA, RDATA.
REQ-004 IDLE -> CMD on the cycle devsel_i=1 with rw_bit_i=0; IDLE -> RDATA on the cycle devsel_i=1 with rw_bit_i=1.
REQ-005 CMD: on rxbyte_v_i, latch rxbyte_i into cmd register; go to WDATA.
REQ-006 WDATA: each rxbyte_v_i executes one write to the current cmd; state stays WDATA; cmd does not auto-increment.
REQ-007 Any state -> IDLE on the cycle devsel_i=0; cmd register is retained, so a repeated-start read uses the last written cmd.
REQ-008 If devsel_i stays 1 but rw_bit_i changes (repeated start without stop), the FSM re-enters CMD or RDATA per the new rw_bit_i in the next cycle.
REQ-009 Write actions:
- cmd 0x01: data 0x00 -> pwroff_req_o pulse; data 0x01 -> reset_req_o pulse; other data ignored.
- cmd 0x02: any data -> reset_req_o pulse.
- cmd 0x05: led_o <= data.
- All other cmds: write ignored.
REQ-010 Pulses assert the cycle after rxbyte_v_i and last exactly 1 cycle.
REQ-011 txbyte_o is registered and depends on cmd:
- 0x05: led_o.
- 0x07: FIFO head, or 8'h00 when the FIFO is empty.
- 0x30: FW_VERSION.
- Otherwise: 8'hFF.
txbyte_o is updated no later than 1 cycle after entering RDATA or after txbyte_deq_i.
REQ-012 txbyte_deq_i in RDATA with cmd=0x07 and FIFO non-empty pops one entry; no pop when empty; a deq for any other cmd has no side effect.
REQ-013 Keyboard FIFO:
- KBD_DEPTH entries; read/write pointers are log2(KBD_DEPTH)+1 bits wide and wrap modulo 2*KBD_DEPTH.
- full when the pointers differ only in the MSB; empty when they are equal.
REQ-014 kbd_wr_i while full: data dropped, pointers unchanged.
REQ-015 Simultaneous push and pop:
- Both take effect in the same cycle.
- When empty, the pop is suppressed and the push proceeds.
- When full, the push proceeds because the pop frees a slot.
REQ-016 kbd_full_o is combinational from the pointers.

Reset
REQ-017 Reset values: state=IDLE, cmd=8'h00, led_o=8'h00, txbyte_o=8'hFF, FIFO pointers=0, pwroff_req_o=0, reset_req_o=0.
REQ-018 Reset asserted mid-transfer aborts immediately. After release, the FSM waits in IDLE until devsel_i is seen at 1.

Structure
REQ-019 A shared package holds:
- command code constants: CMD_POWER=8'h01, CMD_RESET=8'h02, CMD_LED=8'h05, CMD_KBD=8'h07, CMD_VERSION=8'h30.
- the FSM state encoding.
REQ-020 The keyboard FIFO is one sub-module, smc_fifo (parameterised width and depth), instantiated once.

Verification
REQ-021 Write 0x05, 0xA5 -> led_o=8'hA5 one cycle after the second rxbyte_v_i; no pulses asserted.
REQ-022 Write 0x01, 0x00 -> pwroff_req_o high for exactly 1 cycle.
REQ-023 Write 0x01, 0x01 -> reset_req_o high for exactly 1 cycle.
REQ-024 Push 0x1C, 0x32, then write cmd 0x07, repeated-start read of 3 bytes -> 0x1C, 0x32, 0x00; FIFO empty after the reads.
REQ-025 Push 9 bytes 0x01..0x09 with KBD_DEPTH=8 -> kbd_full_o=1 after the 8th push; 0x09 dropped; reads return 0x01..0x08.
REQ-026 Assert resetn=0 during WDATA with led_o=8'h3C:
- led_o=8'h00, state=IDLE.
- A subsequent read with cmd 0x30 returns FW_VERSION.
